// File: rtl/data_port_arbiter.sv
// Purpose: shares one OBI-style data memory port between the scalar core LSU and the vector LSU (round-robin, in-order response routing).
// Latency: zero-cycle request pass-through and zero-cycle rvalid routing; no bubbles while the owner FIFO has room.
// Backpressure: a request is held (selection locked) until mem_gnt_i; issue stalls while MAX_OUTSTANDING responses are pending.
module data_port_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                core_req_i,
  output logic                core_gnt_o,
  output logic                core_rvalid_o,
  input  logic                core_we_i,
  input  logic [DATA_W/8-1:0] core_be_i,
  input  logic [ADDR_W-1:0]   core_addr_i,
  input  logic [DATA_W-1:0]   core_wdata_i,
  output logic [DATA_W-1:0]   core_rdata_o,
  input  logic                vlsu_req_i,
  output logic                vlsu_gnt_o,
  output logic                vlsu_rvalid_o,
  input  logic                vlsu_we_i,
  input  logic [DATA_W/8-1:0] vlsu_be_i,
  input  logic [ADDR_W-1:0]   vlsu_addr_i,
  input  logic [DATA_W-1:0]   vlsu_wdata_i,
  output logic [DATA_W-1:0]   vlsu_rdata_o,
  output logic                mem_req_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                busy_o,
  output logic                err_o
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_CORE = 2'd1,
    SEL_VLSU = 2'd2
  } sel_e;

  // Arbitration state: lock keeps a pending request's master selected.
  logic          r_lock;
  sel_e          r_locked_sel;
  logic          r_last_vlsu;
  logic          r_err;
  // Owner FIFO: one bit per outstanding transaction, 1 = VLSU.
  logic          r_owner [MAX_OUTSTANDING];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  sel_e          w_sel;
  logic          w_sel_req;
  logic          w_full;
  logic          w_hs;
  logic          w_pop;
  logic          w_head_vlsu;
  logic          w_lock_nxt;
  logic [PW-1:0] w_wr_ptr_nxt;
  logic [PW-1:0] w_rd_ptr_nxt;
  logic [CW-1:0] w_count_nxt;

  assign w_full = (r_count == CW'(MAX_OUTSTANDING));

  // Select the master: locked choice first, else the sole requester, else the one that did not win last.
  always_comb begin
    w_sel = SEL_NONE;
    if (r_lock)                          w_sel = r_locked_sel;
    else if (core_req_i && !vlsu_req_i)  w_sel = SEL_CORE;
    else if (vlsu_req_i && !core_req_i)  w_sel = SEL_VLSU;
    else if (core_req_i && vlsu_req_i)   w_sel = r_last_vlsu ? SEL_CORE : SEL_VLSU;
  end

  assign w_sel_req = ((w_sel == SEL_CORE) && core_req_i) || ((w_sel == SEL_VLSU) && vlsu_req_i);
  // Gated by n_reset so nothing is issued or granted during reset cycles.
  assign mem_req_o = w_sel_req && !w_full && n_reset;
  assign w_hs      = mem_req_o && mem_gnt_i;

  assign core_gnt_o = w_hs && (w_sel == SEL_CORE);
  assign vlsu_gnt_o = w_hs && (w_sel == SEL_VLSU);

  // Route the selected master's attributes to memory; all zero when idle.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (w_sel == SEL_CORE) begin
      mem_we_o    = core_we_i;
      mem_be_o    = core_be_i;
      mem_addr_o  = core_addr_i;
      mem_wdata_o = core_wdata_i;
    end else if (w_sel == SEL_VLSU) begin
      mem_we_o    = vlsu_we_i;
      mem_be_o    = vlsu_be_i;
      mem_addr_o  = vlsu_addr_i;
      mem_wdata_o = vlsu_wdata_i;
    end
  end

  assign w_head_vlsu   = r_owner[r_rd_ptr];
  assign w_pop         = mem_rvalid_i && (r_count != '0) && n_reset;
  assign core_rvalid_o = w_pop && !w_head_vlsu;
  assign vlsu_rvalid_o = w_pop && w_head_vlsu;
  assign core_rdata_o  = mem_rdata_i;
  assign vlsu_rdata_o  = mem_rdata_i;
  assign busy_o        = (r_count != '0) && n_reset;
  assign err_o         = r_err;

  // Next-state for lock and the owner FIFO bookkeeping.
  always_comb begin
    w_lock_nxt   = (w_sel != SEL_NONE) && w_sel_req && !w_hs;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    if (w_hs)  w_wr_ptr_nxt = (r_wr_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_wr_ptr + PW'(1);
    if (w_pop) w_rd_ptr_nxt = (r_rd_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_rd_ptr + PW'(1);
    if (w_hs && !w_pop)      w_count_nxt = r_count + CW'(1);
    else if (!w_hs && w_pop) w_count_nxt = r_count - CW'(1);
  end

  // Register arbitration and FIFO control state; reset discards all outstanding ownership.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_lock       <= 1'b0;
      r_locked_sel <= SEL_NONE;
      r_last_vlsu  <= 1'b1;
      r_err        <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
    end else begin
      r_lock   <= w_lock_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      if (w_lock_nxt) r_locked_sel <= w_sel;
      if (w_hs)       r_last_vlsu  <= (w_sel == SEL_VLSU);
      if (mem_rvalid_i && (r_count == '0)) r_err <= 1'b1;
    end
  end

  // Record the owner of each granted transaction at the write pointer.
  always_ff @(posedge clk) begin
    if (w_hs) r_owner[r_wr_ptr] <= (w_sel == SEL_VLSU);
  end

endmodule
